// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions for the TX engine and the RX side.
//   - utx_state_t     : transmit FSM state encoding
//   - UART_IDLE_LVL   : serial line level when nothing is being sent
//   - UART_DATA_WIDTH : default data bits per frame
//   - UART_DIV_WIDTH  : default width of the baud divisor
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int   UART_DATA_WIDTH = 8;
    localparam int   UART_DIV_WIDTH  = 16;
    localparam logic UART_IDLE_LVL   = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } utx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Bit-period divider. Counts 0 .. div-1 and wraps; bit_end_o marks the last
// clock of each bit period.
//   clk_i     : clock
//   rst_i     : synchronous active-high reset (count = 0)
//   clr_i     : holds the count at 0 (used while idle and on frame load)
//   div_i     : clocks per bit; 0 behaves as 1
//   bit_end_o : high on the last clock of a bit period
// -----------------------------------------------------------------------------
module uart_baud_gen #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 bit_end_o
);

    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] cnt_d;
    logic [DIV_WIDTH-1:0] last_cnt;

    // Comparing against div-1 keeps the counter inside DIV_WIDTH bits.
    always_comb begin
        last_cnt = (div_i == '0) ? '0 : div_i - 1'b1;
        bit_end_o = (cnt_q == last_cnt);
        if (clr_i || bit_end_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_engine.sv
// -----------------------------------------------------------------------------
// uart_tx_engine
// UART transmit serializer fed by a first-word-fall-through FIFO. Pops one word
// when idle and the FIFO is non-empty, then sends start, data LSB-first,
// optional parity and 1 or 2 stop bits on tx_o.
//   utx_clk_i        : clock, shared with the FIFO
//   utx_rst_i        : synchronous active-high reset
//   cfg_baud_div_i   : clocks per bit (0 behaves as 1), latched on load
//   cfg_parity_en_i  : insert parity bit, latched on load
//   cfg_parity_odd_i : 1 = odd parity, 0 = even, latched on load
//   cfg_two_stop_i   : 1 = two stop bits, latched on load
//   fifo_data_i      : FIFO head word
//   fifo_empty_i     : FIFO empty flag
//   fifo_rd_en_o     : pop strobe, one clock per word (combinational)
//   tx_o             : registered serial line, idles high
//   tx_busy_o        : high while a frame is in flight
//
// FIFO handshake: a word is transferred in the clock where fifo_rd_en_o is high,
// which is exactly the clock where fifo_data_i is captured. fifo_data_i is
// ignored in every other clock.
// -----------------------------------------------------------------------------
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int DIV_WIDTH  = UART_DIV_WIDTH
) (
    input  logic                  utx_clk_i,
    input  logic                  utx_rst_i,
    input  logic [DIV_WIDTH-1:0]  cfg_baud_div_i,
    input  logic                  cfg_parity_en_i,
    input  logic                  cfg_parity_odd_i,
    input  logic                  cfg_two_stop_i,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    input  logic                  fifo_empty_i,
    output logic                  fifo_rd_en_o,
    output logic                  tx_o,
    output logic                  tx_busy_o
);

    localparam int BIT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    utx_state_t            state_q,    state_d;
    logic [DATA_WIDTH-1:0] shift_q,    shift_d;
    logic [DATA_WIDTH-1:0] word_q,     word_d;
    logic [DIV_WIDTH-1:0]  div_q,      div_d;
    logic                  par_en_q,   par_en_d;
    logic                  par_odd_q,  par_odd_d;
    logic                  two_stop_q, two_stop_d;
    logic [BIT_W-1:0]      bit_idx_q,  bit_idx_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic                  tx_q,       tx_d;

    logic load;
    logic bit_end;
    logic baud_clr;

    assign load     = (state_q == IDLE) && !fifo_empty_i && !utx_rst_i;
    // Holding the divider cleared through IDLE makes the first bit start at 0.
    assign baud_clr = (state_q == IDLE);

    uart_baud_gen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_baud_gen (
        .clk_i     (utx_clk_i),
        .rst_i     (utx_rst_i),
        .clr_i     (baud_clr),
        .div_i     (div_q),
        .bit_end_o (bit_end)
    );

    // State register
    always_ff @(posedge utx_clk_i) begin
        if (utx_rst_i) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            word_q     <= '0;
            div_q      <= '0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            two_stop_q <= 1'b0;
            bit_idx_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= UART_IDLE_LVL;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            word_q     <= word_d;
            div_q      <= div_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            two_stop_q <= two_stop_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        word_d     = word_q;
        div_d      = div_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        two_stop_d = two_stop_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (load) begin
                    state_d    = START;
                    shift_d    = fifo_data_i;
                    word_d     = fifo_data_i;
                    div_d      = cfg_baud_div_i;
                    par_en_d   = cfg_parity_en_i;
                    par_odd_d  = cfg_parity_odd_i;
                    two_stop_d = cfg_two_stop_i;
                    bit_idx_d  = '0;
                    stop_cnt_d = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d    = par_en_q ? PARITY : STOP;
                        stop_cnt_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d    = STOP;
                    stop_cnt_d = 1'b0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (two_stop_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic. tx is registered, so its next value is decoded from the
    // next state; this puts the start bit on the line the clock after the load.
    always_comb begin
        tx_d = UART_IDLE_LVL;
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            // Parity uses the captured word since the shift register has moved on.
            PARITY:  tx_d = (^word_q) ^ par_odd_q;
            default: tx_d = UART_IDLE_LVL;
        endcase
    end

    assign fifo_rd_en_o = load;
    assign tx_o         = tx_q;
    assign tx_busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_engine.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_engine
// Bench for uart_tx_engine. A FIFO model feeds words; each sent word pushes a
// frame descriptor into the expected queue. A monitor expands the descriptor
// into per-clock line levels on each pop and compares tx_o, tx_busy_o and
// fifo_rd_en_o every clock.
// -----------------------------------------------------------------------------
module tb_uart_tx_engine;

    localparam int DW = 8;
    localparam int VW = 16;

    typedef struct packed {
        logic [DW-1:0] word;
        logic [VW-1:0] div;
        logic          pe;
        logic          po;
        logic          ts;
    } frame_t;

    // Clock / reset / DUT signals
    logic          clk;
    logic          rst;
    logic [VW-1:0] cfg_baud_div;
    logic          cfg_parity_en;
    logic          cfg_parity_odd;
    logic          cfg_two_stop;
    logic [DW-1:0] fifo_data;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic          tx;
    logic          tx_busy;

    // Scoreboard and model state
    frame_t        exp_q[$];
    logic [DW-1:0] fifo_q[$];
    logic          lvl_q[$];
    int unsigned   pop_t[$];
    int            checks = 0;
    int            errors = 0;
    int unsigned   cyc = 0;
    logic [VW-1:0] m_div;
    logic          m_pe;
    logic          m_po;
    logic          m_ts;

    uart_tx_engine #(
        .DATA_WIDTH (DW),
        .DIV_WIDTH  (VW)
    ) dut (
        .utx_clk_i        (clk),
        .utx_rst_i        (rst),
        .cfg_baud_div_i   (cfg_baud_div),
        .cfg_parity_en_i  (cfg_parity_en),
        .cfg_parity_odd_i (cfg_parity_odd),
        .cfg_two_stop_i   (cfg_two_stop),
        .fifo_data_i      (fifo_data),
        .fifo_empty_i     (fifo_empty),
        .fifo_rd_en_o     (fifo_rd_en),
        .tx_o             (tx),
        .tx_busy_o        (tx_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference frame: list of bit values, each held for div clocks.
    task automatic expand(input frame_t f);
        int   d;
        logic bits[$];
        d = (f.div == '0) ? 1 : int'(f.div);
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(f.word[i]);
        if (f.pe) bits.push_back((^f.word) ^ f.po);
        bits.push_back(1'b1);
        if (f.ts) bits.push_back(1'b1);
        foreach (bits[i]) begin
            for (int k = 0; k < d; k++) lvl_q.push_back(bits[i]);
        end
    endtask

    task automatic fifo_drive();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : DW'($urandom);
    endtask

    // FIFO model: pop takes effect after the clock edge where rd_en was high.
    initial begin
        logic p;
        fifo_drive();
        forever begin
            @(negedge clk);
            p = fifo_rd_en;
            @(posedge clk);
            #1;
            if (p && fifo_q.size() != 0) void'(fifo_q.pop_front());
            fifo_drive();
        end
    end

    // Monitor
    initial begin
        logic rst_prev;
        logic lvl;
        rst_prev = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                chk("rd_en_in_reset", 32'(fifo_rd_en), 32'd0);
                if (rst_prev) begin
                    chk("tx_in_reset", 32'(tx), 32'd1);
                    chk("busy_in_reset", 32'(tx_busy), 32'd0);
                end
                lvl_q.delete();
            end else if (lvl_q.size() != 0) begin
                lvl = lvl_q.pop_front();
                chk("tx_bit", 32'(tx), 32'(lvl));
                chk("busy_frame", 32'(tx_busy), 32'd1);
                chk("rd_en_frame", 32'(fifo_rd_en), 32'd0);
            end else begin
                chk("tx_idle", 32'(tx), 32'd1);
                chk("busy_idle", 32'(tx_busy), 32'd0);
                chk("rd_en_idle", 32'(fifo_rd_en), 32'(fifo_q.size() != 0));
                if (fifo_rd_en) begin
                    pop_t.push_back(cyc);
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL pop_expected: got pop, expected no pending word (cycle %0d)", cyc);
                    end else begin
                        expand(exp_q.pop_front());
                    end
                end
            end
            rst_prev = rst;
        end
    end

    // Driver tasks
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_cfg(input int div, input logic pe, input logic po, input logic ts);
        cfg_baud_div   = VW'(div);
        cfg_parity_en  = pe;
        cfg_parity_odd = po;
        cfg_two_stop   = ts;
        m_div = VW'(div);
        m_pe  = pe;
        m_po  = po;
        m_ts  = ts;
    endtask

    task automatic send(input logic [DW-1:0] w);
        frame_t f;
        f.word = w;
        f.div  = m_div;
        f.pe   = m_pe;
        f.po   = m_po;
        f.ts   = m_ts;
        fifo_q.push_back(w);
        exp_q.push_back(f);
        fifo_drive();
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((fifo_q.size() != 0 || lvl_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            step(1);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL idle_timeout: got still busy after %0d cycles, expected idle", budget);
        end
        step(2);
    endtask

    task automatic wait_pop(input int budget);
        int n;
        int k;
        n = 0;
        k = pop_t.size();
        while (pop_t.size() == k && n < budget) begin
            step(1);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL pop_timeout: got no pop in %0d cycles, expected one", budget);
        end
    endtask

    // Stimulus
    initial begin
        rst = 1'b1;
        set_cfg(4, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        step(3);

        // Basic frame
        send(8'h55);
        wait_idle(200);

        // Parity even / odd, then two stop bits
        set_cfg(2, 1'b1, 1'b0, 1'b0);
        send(8'h07);
        wait_idle(200);
        set_cfg(2, 1'b1, 1'b1, 1'b0);
        send(8'h07);
        wait_idle(200);
        set_cfg(2, 1'b1, 1'b0, 1'b1);
        send(8'h07);
        wait_idle(200);

        // Back-to-back at div 1
        set_cfg(1, 1'b0, 1'b0, 1'b0);
        send(8'hA5);
        send(8'h3C);
        wait_idle(200);
        chk("b2b_pop_spacing", pop_t[pop_t.size()-1] - pop_t[pop_t.size()-2], 32'd11);

        // Divisor change during DATA
        set_cfg(4, 1'b0, 1'b0, 1'b0);
        send(8'h96);
        wait_pop(50);
        step(10);
        set_cfg(8, 1'b0, 1'b0, 1'b0);
        send(8'h69);
        wait_idle(400);

        // Reset during data bit 3, next word follows cleanly
        set_cfg(4, 1'b0, 1'b0, 1'b0);
        send(8'hF0);
        send(8'h0F);
        wait_pop(50);
        step(17);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        wait_idle(400);

        // Divisor 0 behaves as 1
        set_cfg(0, 1'b1, 1'b1, 1'b1);
        send(8'hC3);
        send(8'h81);
        wait_idle(200);

        // Randomized batches
        for (int b = 0; b < 12; b++) begin
            int nw;
            set_cfg($urandom_range(0, 5), 1'($urandom), 1'($urandom), 1'($urandom));
            nw = $urandom_range(1, 3);
            for (int i = 0; i < nw; i++) send(DW'($urandom));
            wait_idle(400);
        end

        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
